// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALUOp/ALUControl codes and datapath select values.
package multicycle_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction funct fields to
// the ALUControl code driven to the shared ALU.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  // funct3 000 is sub only for R-type (op[5]=1) with funct7b5 set
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000: begin
            if (op5_i && funct7b5_i) alu_control_o = ALU_SUB;
            else                     alu_control_o = ALU_ADD;
          end
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core. Defining
// MULTICYCLE_ILLEGAL_TRAP_EN adds a TRAP state and the Illegal output.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int RESET_STATE_W = 4
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic       Illegal
`endif
);

  logic [RESET_STATE_W-1:0] state_q;
  state_e                   state_s;
  state_e                   state_d;

  logic       pc_write_s;
  logic       ir_write_s;
  logic       mem_write_s;
  logic       reg_write_s;
  logic       adr_src_s;
  logic [1:0] result_src_s;
  logic [1:0] alu_src_a_s;
  logic [1:0] alu_src_b_s;
  logic [1:0] alu_op_s;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       illegal_s;
`endif

  assign state_s = state_e'(state_q[STATE_W-1:0]);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE_W'(S_FETCH);
    else        state_q <= RESET_STATE_W'(state_d);
  end

  // Next state and Moore outputs; FETCH/BEQ strobes also follow MemReady/Zero
  always_comb begin
    state_d      = state_s;
    pc_write_s   = 1'b0;
    ir_write_s   = 1'b0;
    mem_write_s  = 1'b0;
    reg_write_s  = 1'b0;
    adr_src_s    = 1'b0;
    result_src_s = RES_ALUOUT;
    alu_src_a_s  = SRCA_PC;
    alu_src_b_s  = SRCB_RD2;
    alu_op_s     = ALUOP_ADD;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_s    = 1'b0;
`endif
    case (state_s)
      S_FETCH: begin
        result_src_s = RES_ALURESULT;
        alu_src_b_s  = SRCB_FOUR;
        pc_write_s   = MemReady;
        ir_write_s   = MemReady;
        if (MemReady) state_d = S_DECODE;
        else          state_d = S_FETCH;
      end
      S_DECODE: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a_s = SRCA_RD1;
        alu_src_b_s = SRCB_IMM;
        if (op == OP_LW) state_d = S_MEMREAD;
        else             state_d = S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src_s = 1'b1;
        if (MemReady) state_d = S_MEMWB;
        else          state_d = S_MEMREAD;
      end
      S_MEMWB: begin
        result_src_s = RES_DATA;
        reg_write_s  = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src_s   = 1'b1;
        mem_write_s = 1'b1;
        if (MemReady) state_d = S_FETCH;
        else          state_d = S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a_s = SRCA_RD1;
        alu_op_s    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a_s = SRCA_RD1;
        alu_src_b_s = SRCB_IMM;
        alu_op_s    = ALUOP_FUNCT;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_s = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a_s = SRCA_RD1;
        alu_op_s    = ALUOP_SUB;
        pc_write_s  = Zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        alu_src_a_s = SRCA_OLDPC;
        alu_src_b_s = SRCB_FOUR;
        pc_write_s  = 1'b1;
        state_d     = S_ALUWB;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_s = 1'b1;
        state_d   = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Immediate format from opcode; unknown opcodes fall back to I-format
  always_comb begin
    ImmSrc = IMM_I;
    case (op)
      OP_LW, OP_I: ImmSrc = IMM_I;
      OP_SW:       ImmSrc = IMM_S;
      OP_BEQ:      ImmSrc = IMM_B;
      OP_JAL:      ImmSrc = IMM_J;
      default:     ImmSrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op_s),
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .op5_i         (op[5]),
    .alu_control_o (ALUControl)
  );

  // Strobes are gated by rst_n so they drop the instant reset asserts
  assign PCWrite   = pc_write_s  & rst_n;
  assign IRWrite   = ir_write_s  & rst_n;
  assign MemWrite  = mem_write_s & rst_n;
  assign RegWrite  = reg_write_s & rst_n;
  assign AdrSrc    = adr_src_s;
  assign ResultSrc = result_src_s;
  assign ALUSrcA   = alu_src_a_s;
  assign ALUSrcB   = alu_src_b_s;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign Illegal   = illegal_s;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction expected output
// sequences built from latency/stall rules, table vectors plus random ops.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       Illegal;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_STATE_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , .Illegal(Illegal)
`endif
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       memw;
    logic       irw;
    logic [1:0] res;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] aluc;
    logic [1:0] imm;
    logic       regw;
  } exp_t;

  typedef struct {
    logic mr;
    logic z;
    exp_t e;
  } step_t;

  typedef struct {
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    int         fst;
    int         mst;
    logic [1:0] imm;
    logic [2:0] aluc;
  } vec_t;

  step_t q[$];
  string tags[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;

  function automatic exp_t mk(input logic pcw, input logic adr, input logic memw,
                              input logic irw, input logic [1:0] res, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] aluc,
                              input logic [1:0] imm, input logic regw);
    exp_t e;
    e = '{pcw, adr, memw, irw, res, sa, sb, aluc, imm, regw};
    return e;
  endfunction

  function automatic vec_t mkv(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input int fst, input int mst,
                               input logic [1:0] imm, input logic [2:0] aluc);
    vec_t v;
    v = '{o, f3, f7, z, fst, mst, imm, aluc};
    return v;
  endfunction

  function automatic exp_t act();
    exp_t a;
    a = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
         ALUControl, ImmSrc, RegWrite};
    return a;
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] ref_imm(input logic [6:0] o);
    if (o == SW)       return 2'b01;
    else if (o == BEQ) return 2'b10;
    else if (o == JAL) return 2'b11;
    else               return 2'b00;
  endfunction

  function automatic logic [2:0] ref_funct(input logic op5, input logic [2:0] f3, input logic f7);
    if (f3 == 3'b000)      return (op5 && f7) ? 3'b001 : 3'b000;
    else if (f3 == 3'b010) return 3'b101;
    else if (f3 == 3'b110) return 3'b011;
    else if (f3 == 3'b111) return 3'b010;
    else                   return 3'b000;
  endfunction

  task automatic chk(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (pcw adr memw irw res sa sb aluc imm regw)",
               name, a, e);
    end
  endtask

  task automatic chk_bit(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, a, e);
    end
  endtask

  task automatic add(input logic mr, input logic z, input exp_t e, input string t);
    step_t s;
    s.mr = mr;
    s.z  = z;
    s.e  = e;
    q.push_back(s);
    tags.push_back(t);
  endtask

  // Expected per-cycle sequence for one instruction; stalls add MemReady=0 cycles
  task automatic build(input vec_t v);
    logic [1:0] im;
    im = v.imm;
    q.delete();
    tags.delete();
    for (int i = 0; i < v.fst; i++)
      add(1'b0, rbit(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, im, 0), "FETCH_stall");
    add(1'b1, rbit(), mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 3'b000, im, 0), "FETCH");
    add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, im, 0), "DECODE");
    if (v.op == LW || v.op == SW)
      add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, im, 0), "MEMADR");
    if (v.op == LW) begin
      for (int i = 0; i < v.mst; i++)
        add(1'b0, rbit(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0), "MEMREAD_stall");
      add(1'b1, rbit(), mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0), "MEMREAD");
      add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, im, 1), "MEMWB");
    end else if (v.op == SW) begin
      for (int i = 0; i < v.mst; i++)
        add(1'b0, rbit(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0), "MEMWRITE_stall");
      add(1'b1, rbit(), mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 0), "MEMWRITE");
    end else if (v.op == RT || v.op == IT) begin
      add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b10, (v.op == IT) ? 2'b01 : 2'b00,
                             v.aluc, im, 0), "EXECUTE");
      add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1), "ALUWB");
    end else if (v.op == BEQ) begin
      add(rbit(), v.z, mk(v.z, 0, 0, 0, 2'b00, 2'b10, 2'b00, v.aluc, im, 0), "BEQ");
    end else if (v.op == JAL) begin
      add(rbit(), rbit(), mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, im, 0), "JAL");
      add(rbit(), rbit(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, im, 1), "ALUWB");
    end
  endtask

  // Starts and ends at a falling edge; each step is one clock cycle
  task automatic apply(input int n);
    for (int i = 0; i < n && i < q.size(); i++) begin
      MemReady = q[i].mr;
      Zero     = q[i].z;
      #1;
      chk(tags[i], act(), q[i].e);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      chk_bit({tags[i], "_Illegal"}, Illegal, 1'b0);
`endif
      @(negedge clk);
    end
  endtask

  task automatic run(input vec_t v);
    op       = v.op;
    funct3   = v.f3;
    funct7b5 = v.f7;
    build(v);
    apply(q.size());
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b0; MemReady = 1'b1;
    #2;
    chk("reset", act(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0));
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back(mkv(LW,  3'b010, 1'b0, 1'b0, 0, 0, 2'b00, 3'b000));
    vecs.push_back(mkv(SW,  3'b010, 1'b0, 1'b0, 0, 3, 2'b01, 3'b000));
    vecs.push_back(mkv(BEQ, 3'b000, 1'b0, 1'b1, 0, 0, 2'b10, 3'b001));
    vecs.push_back(mkv(BEQ, 3'b000, 1'b0, 1'b0, 0, 0, 2'b10, 3'b001));
    vecs.push_back(mkv(RT,  3'b000, 1'b1, 1'b0, 0, 0, 2'b00, 3'b001));
    vecs.push_back(mkv(RT,  3'b110, 1'b0, 1'b0, 0, 0, 2'b00, 3'b011));
    vecs.push_back(mkv(RT,  3'b111, 1'b1, 1'b0, 0, 0, 2'b00, 3'b010));
    vecs.push_back(mkv(RT,  3'b010, 1'b0, 1'b0, 0, 0, 2'b00, 3'b101));
    vecs.push_back(mkv(IT,  3'b000, 1'b1, 1'b0, 0, 0, 2'b00, 3'b000));
    vecs.push_back(mkv(IT,  3'b100, 1'b0, 1'b0, 0, 0, 2'b00, 3'b000));
    vecs.push_back(mkv(JAL, 3'b000, 1'b0, 1'b0, 0, 0, 2'b11, 3'b000));
    vecs.push_back(mkv(LW,  3'b010, 1'b0, 1'b0, 2, 2, 2'b00, 3'b000));
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    vecs.push_back(mkv(BAD, 3'b000, 1'b0, 1'b0, 1, 0, 2'b00, 3'b000));
`endif
    vecs.push_back(mkv(RT,  3'b000, 1'b0, 1'b0, 0, 0, 2'b00, 3'b000));
    for (int i = 0; i < vecs.size(); i++) run(vecs[i]);

    // Reset asserted mid-MEMWRITE while the store strobe is high
    v = mkv(SW, 3'b010, 1'b0, 1'b0, 0, 3, 2'b01, 3'b000);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    build(v);
    apply(3);
    MemReady = 1'b0;
    #1;
    chk("MEMWRITE_before_reset", act(), q[3].e);
    #1;
    rst_n = 1'b0;
    MemReady = 1'b1;
    #1;
    chk("reset_mid_MEMWRITE", act(), mk(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 2'b01, 0));
    @(negedge clk);
    rst_n = 1'b1;
    run(mkv(LW, 3'b010, 1'b0, 1'b0, 0, 1, 2'b00, 3'b000));

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    v = mkv(BAD, 3'b000, 1'b0, 1'b0, 0, 0, 2'b00, 3'b000);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7;
    build(v);
    apply(q.size());
    for (int i = 0; i < 3; i++) begin
      MemReady = 1'b1;
      Zero = rbit();
      #1;
      chk("TRAP", act(), mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
      chk_bit("TRAP_Illegal", Illegal, 1'b1);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk_bit("TRAP_reset_Illegal", Illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Random instruction stream with random stalls
    for (int n = 0; n < 60; n++) begin
      logic [6:0] ops[7];
      logic [6:0] o;
      logic [2:0] f3;
      logic       f7;
      logic [2:0] ac;
      ops = '{LW, SW, RT, IT, BEQ, JAL, 7'b0110111};
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      o = ops[$urandom_range(0, 5)];
`else
      o = ops[$urandom_range(0, 6)];
`endif
      f3 = 3'($urandom_range(0, 7));
      f7 = rbit();
      if (o == BEQ)                 ac = 3'b001;
      else if (o == RT || o == IT)  ac = ref_funct(o[5], f3, f7);
      else                          ac = 3'b000;
      run(mkv(o, f3, f7, rbit(), $urandom_range(0, 2), $urandom_range(0, 3), ref_imm(o), ac));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
